// File: rtl/twofish_io_pkg.sv
// Shared types and elaboration helpers for the Twofish switch/LED front end.
//   phase_e         : sequencer phase, encodings 0..4 are visible on phase_led
//   calc_idx_w()    : width of the word/chunk index for a given geometry
//   geometry_ok()   : true when key/block widths divide evenly into words/chunks
package twofish_io_pkg;

  typedef enum logic [2:0] {
    PH_LOAD_KEY  = 3'd0,
    PH_LOAD_DATA = 3'd1,
    PH_START     = 3'd2,
    PH_WAIT      = 3'd3,
    PH_SHOW      = 3'd4
  } phase_e;

  // Index must cover the longest of key words, block words and LED chunks.
  // Clamped to 1 so a single-word geometry still gets a real signal.
  function automatic int calc_idx_w(input int key_w, input int blk_w,
                                    input int sw_w, input int led_w);
    int m;
    int c;
    m = key_w / sw_w;
    if (blk_w / sw_w > m) m = blk_w / sw_w;
    if (blk_w / led_w > m) m = blk_w / led_w;
    c = $clog2(m);
    return (c < 1) ? 1 : c;
  endfunction

  function automatic bit geometry_ok(input int key_w, input int blk_w,
                                     input int sw_w, input int led_w);
    return (sw_w > 0) && (led_w > 0) &&
           (key_w >= sw_w) && (blk_w >= sw_w) && (blk_w >= led_w) &&
           (key_w % sw_w == 0) && (blk_w % sw_w == 0) && (blk_w % led_w == 0);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-debounced level input.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   i_level : sampled level
//   o_rise  : high in the cycle where i_level is high and was low the cycle before
// History resets to 1 so a level held high across reset release yields no edge.
module rise_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_hist;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_hist <= 1'b1;
    else         r_hist <= i_level;
  end

  assign o_rise = i_level & ~r_hist;

endmodule

// File: rtl/sw_led_seq.sv
// Switch/LED sequencer for the Twofish core.
// Loads a key then a data block from slide switches one word per step edge,
// pulses core_start, waits for core_done, then pages the result onto the LEDs
// most-significant chunk first. After the last page it returns to data entry
// with the key retained.
//   man_clk, reset        : clock, synchronous active-high reset
//   bits                  : switch word
//   step, mode_in         : buttons, acted on at their rising edges
//   core_done, core_dout  : completion pulse and result from the core
//   core_start, core_mode : launch pulse and encrypt(0)/decrypt(1)
//   core_key, core_din    : assembled key and data block
//   LED                   : current result chunk (0 outside SHOW)
//   reset_led, mode_led, busy_led, phase_led, state_led : status indicators
module sw_led_seq
  import twofish_io_pkg::*;
#(
  parameter int KEY_W = 128,
  parameter int BLK_W = 128,
  parameter int SW_W  = 16,
  parameter int LED_W = 8,
  parameter int IDX_W = calc_idx_w(KEY_W, BLK_W, SW_W, LED_W)
) (
  input  logic              man_clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   bits,
  input  logic              step,
  input  logic              mode_in,
  input  logic              core_done,
  input  logic [BLK_W-1:0]  core_dout,
  output logic              core_start,
  output logic              core_mode,
  output logic [KEY_W-1:0]  core_key,
  output logic [BLK_W-1:0]  core_din,
  output logic [LED_W-1:0]  LED,
  output logic              reset_led,
  output logic              mode_led,
  output logic              busy_led,
  output logic [2:0]        phase_led,
  output logic [IDX_W-1:0]  state_led
);

  if (!geometry_ok(KEY_W, BLK_W, SW_W, LED_W)) begin : g_bad_geometry
    $error("sw_led_seq: KEY_W/BLK_W must be multiples of SW_W, BLK_W a multiple of LED_W");
  end

  localparam int KEY_WORDS  = KEY_W / SW_W;
  localparam int BLK_WORDS  = BLK_W / SW_W;
  localparam int LED_CHUNKS = BLK_W / LED_W;

  localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_WORDS - 1);
  localparam logic [IDX_W-1:0] BLK_LAST = IDX_W'(BLK_WORDS - 1);
  localparam logic [IDX_W-1:0] LED_LAST = IDX_W'(LED_CHUNKS - 1);

  phase_e             r_phase, w_phase_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [KEY_W-1:0]   r_key, w_key_shift;
  logic [BLK_W-1:0]   r_din, w_din_shift;
  logic [BLK_W-1:0]   r_result;
  logic               r_mode;
  logic               w_step_rise, w_mode_rise;
  logic               w_key_ld, w_din_ld, w_capture, w_mode_tog;
  logic [LED_W-1:0]   w_chunk;

  rise_detect u_step_rise (
    .i_clk   (man_clk),
    .i_reset (reset),
    .i_level (step),
    .o_rise  (w_step_rise)
  );

  rise_detect u_mode_rise (
    .i_clk   (man_clk),
    .i_reset (reset),
    .i_level (mode_in),
    .o_rise  (w_mode_rise)
  );

  // New word enters at the bottom, so the first word entered ends up on top.
  if (KEY_W > SW_W) begin : g_key_shift
    assign w_key_shift = {r_key[KEY_W-SW_W-1:0], bits};
  end else begin : g_key_load
    assign w_key_shift = bits;
  end

  if (BLK_W > SW_W) begin : g_din_shift
    assign w_din_shift = {r_din[BLK_W-SW_W-1:0], bits};
  end else begin : g_din_load
    assign w_din_shift = bits;
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_idx_nxt   = r_idx;
    w_key_ld    = 1'b0;
    w_din_ld    = 1'b0;
    w_capture   = 1'b0;
    // Mode only changes while entering operands, keeping it stable for the core.
    w_mode_tog  = w_mode_rise &&
                  ((r_phase == PH_LOAD_KEY) || (r_phase == PH_LOAD_DATA));
    unique case (r_phase)
      PH_LOAD_KEY: begin
        if (w_step_rise) begin
          w_key_ld = 1'b1;
          if (r_idx == KEY_LAST) begin
            w_idx_nxt   = '0;
            w_phase_nxt = PH_LOAD_DATA;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      PH_LOAD_DATA: begin
        if (w_step_rise) begin
          w_din_ld = 1'b1;
          if (r_idx == BLK_LAST) begin
            w_idx_nxt   = '0;
            w_phase_nxt = PH_START;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      PH_START: begin
        w_phase_nxt = PH_WAIT;
      end
      PH_WAIT: begin
        if (core_done) begin
          w_capture   = 1'b1;
          w_idx_nxt   = '0;
          w_phase_nxt = PH_SHOW;
        end
      end
      PH_SHOW: begin
        if (w_step_rise) begin
          if (r_idx == LED_LAST) begin
            w_idx_nxt   = '0;
            w_phase_nxt = PH_LOAD_DATA;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_phase_nxt = PH_LOAD_KEY;
      end
    endcase
  end

  always_ff @(posedge man_clk) begin
    if (reset) begin
      r_phase  <= PH_LOAD_KEY;
      r_idx    <= '0;
      r_key    <= '0;
      r_din    <= '0;
      r_result <= '0;
      r_mode   <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_idx   <= w_idx_nxt;
      if (w_key_ld)   r_key    <= w_key_shift;
      if (w_din_ld)   r_din    <= w_din_shift;
      if (w_capture)  r_result <= core_dout;
      if (w_mode_tog) r_mode   <= ~r_mode;
    end
  end

  // Constant-index mux keeps every slice static.
  always_comb begin
    w_chunk = '0;
    for (int unsigned i = 0; i < LED_CHUNKS; i++) begin
      if (r_idx == IDX_W'(i)) w_chunk = r_result[BLK_W-1-i*LED_W -: LED_W];
    end
  end

  assign core_start = (r_phase == PH_START);
  assign core_mode  = r_mode;
  assign core_key   = r_key;
  assign core_din   = r_din;
  assign LED        = (r_phase == PH_SHOW) ? w_chunk : '0;
  assign reset_led  = reset;
  assign mode_led   = r_mode;
  assign busy_led   = (r_phase == PH_START) || (r_phase == PH_WAIT);
  assign phase_led  = r_phase;
  assign state_led  = r_idx;

endmodule

// File: tb/tb_sw_led_seq.sv
module tb_sw_led_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Default geometry instance
  logic [15:0]  a_bits = '0;
  logic         a_step = 1'b0, a_mode = 1'b0, a_done = 1'b0;
  logic [127:0] a_dout = '0;
  logic         a_start, a_cmode, a_rled, a_mled, a_busy;
  logic [127:0] a_key, a_din;
  logic [7:0]   a_led;
  logic [2:0]   a_phase;
  logic [3:0]   a_idx;

  sw_led_seq u_dut_a (
    .man_clk(clk), .reset(reset), .bits(a_bits), .step(a_step), .mode_in(a_mode),
    .core_done(a_done), .core_dout(a_dout), .core_start(a_start), .core_mode(a_cmode),
    .core_key(a_key), .core_din(a_din), .LED(a_led), .reset_led(a_rled),
    .mode_led(a_mled), .busy_led(a_busy), .phase_led(a_phase), .state_led(a_idx)
  );

  // Narrow-switch, wide-LED instance
  logic [7:0]   b_bits = '0;
  logic         b_step = 1'b0, b_mode = 1'b0, b_done = 1'b0;
  logic [63:0]  b_dout = '0;
  logic         b_start, b_cmode, b_rled, b_mled, b_busy;
  logic [63:0]  b_key, b_din;
  logic [15:0]  b_led;
  logic [2:0]   b_phase;
  logic [2:0]   b_idx;

  sw_led_seq #(.KEY_W(64), .BLK_W(64), .SW_W(8), .LED_W(16)) u_dut_b (
    .man_clk(clk), .reset(reset), .bits(b_bits), .step(b_step), .mode_in(b_mode),
    .core_done(b_done), .core_dout(b_dout), .core_start(b_start), .core_mode(b_cmode),
    .core_key(b_key), .core_din(b_din), .LED(b_led), .reset_led(b_rled),
    .mode_led(b_mled), .busy_led(b_busy), .phase_led(b_phase), .state_led(b_idx)
  );

  localparam logic [127:0] KEY_EXP  = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [127:0] DIN_EXP  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DOUT_VAL = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus drivers: inputs change on the falling edge, results are read on
  // the following falling edge.
  task automatic press_a(input logic [15:0] w);
    @(negedge clk); a_bits = w; a_step = 1'b1;
    @(negedge clk); a_step = 1'b0;
  endtask

  task automatic press_mode_a();
    @(negedge clk); a_mode = 1'b1;
    @(negedge clk); a_mode = 1'b0;
  endtask

  task automatic done_a(input logic [127:0] v);
    @(negedge clk); a_done = 1'b1; a_dout = v;
    @(negedge clk); a_done = 1'b0;
  endtask

  task automatic press_b(input logic [7:0] w);
    @(negedge clk); b_bits = w; b_step = 1'b1;
    @(negedge clk); b_step = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    #1;
    n_cmp++; if (a_rled !== 1'b1) begin n_bad++; $display("FAIL reset_led_high got %b exp 1", a_rled); end
    @(negedge clk); reset = 1'b0;
    #1;
    n_cmp++; if (a_rled !== 1'b0) begin n_bad++; $display("FAIL reset_led_low got %b exp 0", a_rled); end
    n_cmp++; if (a_phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase got %0d exp 0", a_phase); end
    n_cmp++; if (a_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx got %0d exp 0", a_idx); end
    n_cmp++; if (a_led !== 8'h00) begin n_bad++; $display("FAIL reset_led got %h exp 00", a_led); end
    n_cmp++; if (a_mled !== 1'b0 || a_cmode !== 1'b0) begin n_bad++; $display("FAIL reset_mode got %b/%b exp 0/0", a_mled, a_cmode); end
    n_cmp++; if (a_start !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_start got %b/%b exp 0/0", a_start, a_busy); end
    n_cmp++; if (a_key !== '0 || a_din !== '0) begin n_bad++; $display("FAIL reset_regs got %h %h exp 0", a_key, a_din); end
  endtask

  task automatic test_load_launch();
    for (int k = 1; k <= 8; k++) press_a(16'(k));
    n_cmp++; if (a_phase !== 3'd1 || a_idx !== 4'd0) begin n_bad++; $display("FAIL key_done_phase got %0d/%0d exp 1/0", a_phase, a_idx); end
    n_cmp++; if (a_key !== KEY_EXP) begin n_bad++; $display("FAIL core_key got %h exp %h", a_key, KEY_EXP); end
    for (int k = 1; k <= 7; k++) press_a(16'(k * 16'h1111));
    n_cmp++; if (a_idx !== 4'd7 || a_start !== 1'b0) begin n_bad++; $display("FAIL pre_launch got idx %0d start %b exp 7/0", a_idx, a_start); end
    press_a(16'h8888);
    n_cmp++; if (a_start !== 1'b1 || a_phase !== 3'd2 || a_busy !== 1'b1) begin n_bad++; $display("FAIL start_pulse got %b ph %0d busy %b exp 1/2/1", a_start, a_phase, a_busy); end
    @(negedge clk);
    n_cmp++; if (a_start !== 1'b0 || a_phase !== 3'd3 || a_busy !== 1'b1) begin n_bad++; $display("FAIL start_width got %b ph %0d busy %b exp 0/3/1", a_start, a_phase, a_busy); end
    n_cmp++; if (a_din !== DIN_EXP) begin n_bad++; $display("FAIL core_din got %h exp %h", a_din, DIN_EXP); end
  endtask

  task automatic test_wait_ignores();
    for (int k = 0; k < 3; k++) press_a(16'hFFFF);
    press_mode_a();
    repeat (3) @(negedge clk);
    n_cmp++; if (a_phase !== 3'd3 || a_idx !== 4'd0) begin n_bad++; $display("FAIL wait_step got %0d/%0d exp 3/0", a_phase, a_idx); end
    n_cmp++; if (a_cmode !== 1'b0 || a_mled !== 1'b0) begin n_bad++; $display("FAIL wait_mode got %b exp 0", a_cmode); end
    n_cmp++; if (a_key !== KEY_EXP || a_din !== DIN_EXP || a_led !== 8'h00) begin n_bad++; $display("FAIL wait_stable got %h %h %h", a_key, a_din, a_led); end
  endtask

  task automatic test_show_paging();
    logic [7:0] exp_led;
    done_a(DOUT_VAL);
    n_cmp++; if (a_phase !== 3'd4 || a_busy !== 1'b0) begin n_bad++; $display("FAIL show_phase got %0d busy %b exp 4/0", a_phase, a_busy); end
    n_cmp++; if (a_led !== 8'h00) begin n_bad++; $display("FAIL page0 got %h exp 00", a_led); end
    press_mode_a();
    n_cmp++; if (a_cmode !== 1'b0) begin n_bad++; $display("FAIL show_mode got %b exp 0", a_cmode); end
    for (int k = 1; k <= 15; k++) begin
      press_a(16'h0);
      exp_led = 8'(k * 8'h11);
      n_cmp++; if (a_led !== exp_led || a_idx !== 4'(k)) begin n_bad++; $display("FAIL page%0d got %h idx %0d exp %h", k, a_led, a_idx, exp_led); end
    end
    press_a(16'h0);
    n_cmp++; if (a_phase !== 3'd1 || a_idx !== 4'd0 || a_led !== 8'h00) begin n_bad++; $display("FAIL page_wrap got %0d/%0d/%h exp 1/0/00", a_phase, a_idx, a_led); end
    n_cmp++; if (a_key !== KEY_EXP) begin n_bad++; $display("FAIL key_reuse got %h exp %h", a_key, KEY_EXP); end
  endtask

  task automatic test_step_held();
    @(negedge clk); a_bits = 16'hABCD; a_step = 1'b1;
    repeat (10) @(negedge clk);
    a_step = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_idx !== 4'd1 || a_phase !== 3'd1) begin n_bad++; $display("FAIL step_held got %0d/%0d exp 1/1", a_idx, a_phase); end
    n_cmp++; if (a_din[15:0] !== 16'hABCD) begin n_bad++; $display("FAIL step_held_shift got %h exp abcd", a_din[15:0]); end
  endtask

  task automatic test_mode_gating();
    press_mode_a();
    n_cmp++; if (a_cmode !== 1'b1 || a_mled !== 1'b1) begin n_bad++; $display("FAIL mode_toggle got %b/%b exp 1/1", a_cmode, a_mled); end
    // step and mode edges in the same cycle
    @(negedge clk); a_bits = 16'h1234; a_step = 1'b1; a_mode = 1'b1;
    @(negedge clk); a_step = 1'b0; a_mode = 1'b0;
    n_cmp++; if (a_cmode !== 1'b0 || a_idx !== 4'd2) begin n_bad++; $display("FAIL simultaneous got mode %b idx %0d exp 0/2", a_cmode, a_idx); end
    @(negedge clk); a_mode = 1'b1;
    repeat (5) @(negedge clk);
    a_mode = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_cmode !== 1'b1) begin n_bad++; $display("FAIL mode_held got %b exp 1", a_cmode); end
  endtask

  task automatic test_held_across_reset();
    @(negedge clk); reset = 1'b1; a_step = 1'b1; a_mode = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    a_step = 1'b0; a_mode = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_idx !== 4'd0 || a_phase !== 3'd0) begin n_bad++; $display("FAIL held_reset got %0d/%0d exp 0/0", a_idx, a_phase); end
    n_cmp++; if (a_cmode !== 1'b0 || a_key !== '0) begin n_bad++; $display("FAIL held_reset_regs got %b %h exp 0", a_cmode, a_key); end
  endtask

  task automatic test_spurious_done();
    done_a(DOUT_VAL);
    n_cmp++; if (a_phase !== 3'd0 || a_led !== 8'h00) begin n_bad++; $display("FAIL spurious_done got %0d/%h exp 0/00", a_phase, a_led); end
  endtask

  task automatic test_reset_in_wait();
    for (int k = 0; k < 16; k++) press_a(16'(k + 1));
    @(negedge clk);
    n_cmp++; if (a_phase !== 3'd3) begin n_bad++; $display("FAIL reach_wait got %0d exp 3", a_phase); end
    do_reset();
    n_cmp++; if (a_phase !== 3'd0 || a_key !== '0 || a_din !== '0) begin n_bad++; $display("FAIL wait_reset got %0d %h %h exp 0", a_phase, a_key, a_din); end
    done_a(DOUT_VAL);
    repeat (2) @(negedge clk);
    n_cmp++; if (a_phase !== 3'd0 || a_led !== 8'h00) begin n_bad++; $display("FAIL late_done got %0d/%h exp 0/00", a_phase, a_led); end
  endtask

  task automatic test_width_variant();
    logic [15:0] exp_pg [4];
    exp_pg[0] = 16'h0123; exp_pg[1] = 16'h4567; exp_pg[2] = 16'h89AB; exp_pg[3] = 16'hCDEF;
    for (int k = 1; k <= 8; k++) press_b(8'(k));
    n_cmp++; if (b_phase !== 3'd1 || b_key !== 64'h0102_0304_0506_0708) begin n_bad++; $display("FAIL b_key got %0d %h exp 1 0102030405060708", b_phase, b_key); end
    for (int k = 1; k <= 7; k++) press_b(8'(k * 8'h11));
    n_cmp++; if (b_start !== 1'b0) begin n_bad++; $display("FAIL b_early_start got %b exp 0", b_start); end
    press_b(8'h88);
    n_cmp++; if (b_start !== 1'b1 || b_din !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL b_launch got %b %h exp 1 1122334455667788", b_start, b_din); end
    @(negedge clk);
    n_cmp++; if (b_start !== 1'b0 || b_phase !== 3'd3) begin n_bad++; $display("FAIL b_start_width got %b %0d exp 0/3", b_start, b_phase); end
    @(negedge clk); b_done = 1'b1; b_dout = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); b_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (b_led !== exp_pg[k] || b_phase !== 3'd4) begin n_bad++; $display("FAIL b_page%0d got %h ph %0d exp %h", k, b_led, b_phase, exp_pg[k]); end
      press_b(8'h00);
    end
    n_cmp++; if (b_phase !== 3'd1 || b_idx !== 3'd0 || b_led !== 16'h0) begin n_bad++; $display("FAIL b_wrap got %0d/%0d/%h exp 1/0/0", b_phase, b_idx, b_led); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_load_launch();
    test_wait_ignores();
    test_show_paging();
    test_step_held();
    test_mode_gating();
    test_held_across_reset();
    test_spurious_done();
    test_reset_in_wait();
    test_width_variant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
